// File: rtl/mem_game_pkg.sv
// Shared memory-game definitions: round state encoding, fail codes and the
// sequence geometry common to the RSG and the player-side entry checker.
package mem_game_pkg;

   localparam int SEQ_DEPTH_DEF = 7;
   localparam int DIGIT_W_DEF   = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PASS    = 2'd2,
      ST_FAIL    = 2'd3
   } state_e;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_TIMEOUT  = 2'd2;
   localparam logic [1:0] FC_ILLEGAL  = 2'd3;

   // Round length is level+1 digits, clamped to what the sequence word holds.
   function automatic logic [2:0] seq_len(input logic [2:0] level, input int depth);
      logic [3:0] want;
      want = {1'b0, level} + 4'd1;
      return (want > 4'(depth)) ? 3'(depth) : want[2:0];
   endfunction

endpackage

// File: rtl/seq_entry_checker_if.sv
// Controller <-> entry checker bundle: round start, key entries, result handshake.
// master = game controller side, slave = checker side.
interface seq_entry_checker_if #(
   parameter int SEQ_DEPTH = mem_game_pkg::SEQ_DEPTH_DEF,
   parameter int DIGIT_W   = mem_game_pkg::DIGIT_W_DEF
);
   logic                           start;
   logic [SEQ_DEPTH*DIGIT_W-1:0]   seq_in;
   logic [2:0]                     level_num;
   logic                           key_valid;
   logic [DIGIT_W-1:0]             key_code;
   logic                           result_ack;
   logic                           busy;
   logic [2:0]                     digit_idx;
   logic                           pass;
   logic                           fail;
   logic [1:0]                     fail_code;

   modport master (
      output start, seq_in, level_num, key_valid, key_code, result_ack,
      input  busy, digit_idx, pass, fail, fail_code
   );

   modport slave (
      input  start, seq_in, level_num, key_valid, key_code, result_ack,
      output busy, digit_idx, pass, fail, fail_code
   );
endinterface

// File: rtl/seq_nibble_mux.sv
// Selects the expected digit (nibble idx) out of the latched sequence word.
// Out-of-range indices return zero; they are never compared by the checker.
module seq_nibble_mux #(
   parameter int SEQ_DEPTH = 7,
   parameter int DIGIT_W   = 4
) (
   input  logic [SEQ_DEPTH*DIGIT_W-1:0] seq_word,
   input  logic [2:0]                   idx,
   output logic [DIGIT_W-1:0]           nibble
);
   logic [DIGIT_W-1:0] nib_arr [SEQ_DEPTH];

   for (genvar gi = 0; gi < SEQ_DEPTH; gi++) begin : g_split
      assign nib_arr[gi] = seq_word[gi*DIGIT_W +: DIGIT_W];
   end

   always_comb begin
      nibble = '0;
      for (int i = 0; i < SEQ_DEPTH; i++) begin
         if (idx == 3'(i)) nibble = nib_arr[i];
      end
   end
endmodule

// File: rtl/seq_entry_checker.sv
// Player-side sequence checker: latches the RSG sequence, compares key entries
// one by one and reports pass/fail. Optional inactivity timeout: SEQ_TIMEOUT_EN.
module seq_entry_checker
   import mem_game_pkg::*;
#(
   parameter int SEQ_DEPTH      = SEQ_DEPTH_DEF,
   parameter int DIGIT_W        = DIGIT_W_DEF,
   parameter int MAX_KEY        = 9,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic               clock,
   input  logic               rst,
   seq_entry_checker_if.slave bus
);
   localparam int                 SEQ_W     = SEQ_DEPTH * DIGIT_W;
   localparam logic [DIGIT_W-1:0] MAX_KEY_C = DIGIT_W'(MAX_KEY);

   state_e             state_q, state_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic [2:0]         len_q, len_d;
   logic [2:0]         digit_idx_q, digit_idx_d;
   logic               busy_q, busy_d;
   logic               pass_q, pass_d;
   logic               fail_q, fail_d;
   logic [1:0]         fail_code_q, fail_code_d;

   logic [DIGIT_W-1:0] exp_digit;
   logic               key_illegal;
   logic               key_match;
   logic [2:0]         idx_inc;

`ifdef SEQ_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

   seq_nibble_mux #(
      .SEQ_DEPTH (SEQ_DEPTH),
      .DIGIT_W   (DIGIT_W)
   ) u_nibble_mux (
      .seq_word (seq_q),
      .idx      (digit_idx_q),
      .nibble   (exp_digit)
   );

   assign key_illegal = bus.key_code > MAX_KEY_C;
   assign key_match   = bus.key_code == exp_digit;
   assign idx_inc     = digit_idx_q + 3'd1;

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      len_d       = len_q;
      digit_idx_d = digit_idx_q;
      busy_d      = busy_q;
      pass_d      = pass_q;
      fail_d      = fail_q;
      fail_code_d = fail_code_q;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      // start restarts the round from any state and outranks keys and acks
      if (bus.start) begin
         state_d     = ST_COLLECT;
         seq_d       = bus.seq_in;
         len_d       = seq_len(bus.level_num, SEQ_DEPTH);
         digit_idx_d = 3'd0;
         busy_d      = 1'b1;
         pass_d      = 1'b0;
         fail_d      = 1'b0;
         fail_code_d = FC_NONE;
`ifdef SEQ_TIMEOUT_EN
         to_cnt_d    = '0;
`endif
      end else begin
         case (state_q)
            ST_COLLECT: begin
               if (bus.key_valid) begin
`ifdef SEQ_TIMEOUT_EN
                  to_cnt_d = '0;
`endif
                  if (key_illegal) begin
                     state_d     = ST_FAIL;
                     busy_d      = 1'b0;
                     fail_d      = 1'b1;
                     fail_code_d = FC_ILLEGAL;
                  end else if (!key_match) begin
                     state_d     = ST_FAIL;
                     busy_d      = 1'b0;
                     fail_d      = 1'b1;
                     fail_code_d = FC_MISMATCH;
                  end else begin
                     digit_idx_d = idx_inc;
                     if (idx_inc == len_q) begin
                        state_d = ST_PASS;
                        busy_d  = 1'b0;
                        pass_d  = 1'b1;
                     end
                  end
               end
`ifdef SEQ_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  state_d     = ST_FAIL;
                  busy_d      = 1'b0;
                  fail_d      = 1'b1;
                  fail_code_d = FC_TIMEOUT;
               end else begin
                  to_cnt_d = to_cnt_q + 1'b1;
               end
`endif
            end
            ST_PASS, ST_FAIL: begin
               if (bus.result_ack) begin
                  state_d     = ST_IDLE;
                  pass_d      = 1'b0;
                  fail_d      = 1'b0;
                  fail_code_d = FC_NONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         seq_q       <= '0;
         len_q       <= 3'd0;
         digit_idx_q <= 3'd0;
         busy_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_code_q <= FC_NONE;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         len_q       <= len_d;
         digit_idx_q <= digit_idx_d;
         busy_q      <= busy_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
         fail_code_q <= fail_code_d;
      end
   end

`ifdef SEQ_TIMEOUT_EN
   always_ff @(posedge clock or posedge rst) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`endif

   assign bus.busy      = busy_q;
   assign bus.digit_idx = digit_idx_q;
   assign bus.pass      = pass_q;
   assign bus.fail      = fail_q;
   assign bus.fail_code = fail_code_q;

endmodule
